arc4_seq: RTL and testbench

Top-level sequencer for the ARC4 decryption datapath. It is the initiator side of the en/rdy handshake that init, ksa and prga respond to. On one upstream request it runs the three children in order: init, then ksa, then prga. It owns the single port of the shared S memory and multiplexes that port to whichever child is active. A per-phase watchdog aborts the run if a child never returns rdy.

---
 rtl/arc4_pkg.sv | 17 +
 rtl/arc4_seq_s_port_mux.sv | 27 ++
 rtl/arc4_seq.sv | 96 +++++++++
 tb/tb_arc4_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// arc4_pkg: shared state, phase encodings and S memory geometry for the ARC4 sequencer
package arc4_pkg;
  typedef enum logic [2:0] {
    IDLE, INIT_REQ, INIT_WAIT, KSA_REQ, KSA_WAIT, PRGA_REQ, PRGA_WAIT
  } arc4_seq_state_t;
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;
  localparam int S_DEPTH = 256;
  localparam int AW = $clog2(S_DEPTH);
  function automatic logic [1:0] state_phase(input arc4_seq_state_t s);
    return s == IDLE ? PH_IDLE :
           (s == INIT_REQ || s == INIT_WAIT) ? PH_INIT :
           (s == KSA_REQ  || s == KSA_WAIT)  ? PH_KSA  : PH_PRGA;
  endfunction
endpackage

// File: rtl/arc4_seq_s_port_mux.sv
// s_port_mux: hands the single S memory port to the child owning the current phase
module s_port_mux
  import arc4_pkg::*;
(
  input  logic [1:0]    phase,
  input  logic [AW-1:0] init_addr,
  input  logic [7:0]    init_wrdata,
  input  logic          init_wren,
  input  logic [AW-1:0] ksa_addr,
  input  logic [7:0]    ksa_wrdata,
  input  logic          ksa_wren,
  input  logic [AW-1:0] prga_addr,
  input  logic [7:0]    prga_wrdata,
  input  logic          prga_wren,
  output logic [AW-1:0] s_addr,
  output logic [7:0]    s_wrdata,
  output logic          s_wren
);
  always_comb begin
    s_addr   = phase == PH_INIT ? init_addr   : phase == PH_KSA ? ksa_addr   :
               phase == PH_PRGA ? prga_addr   : '0;
    s_wrdata = phase == PH_INIT ? init_wrdata : phase == PH_KSA ? ksa_wrdata :
               phase == PH_PRGA ? prga_wrdata : '0;
    s_wren   = phase == PH_INIT ? init_wren   : phase == PH_KSA ? ksa_wren   :
               phase == PH_PRGA ? prga_wren   : 1'b0;
  end
endmodule

// File: rtl/arc4_seq.sv
// arc4_seq: runs init, ksa, prga in order on one request, with a per-phase watchdog
module arc4_seq
  import arc4_pkg::*;
#(
  parameter  int TIMEOUT = 16'hFFFF,
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          rdy,
  output logic          err,
  input  logic [23:0]   key,
  output logic [23:0]   key_q,
  output logic          init_en,
  output logic          ksa_en,
  output logic          prga_en,
  input  logic          init_rdy,
  input  logic          ksa_rdy,
  input  logic          prga_rdy,
  input  logic [AW-1:0] init_addr,
  input  logic [AW-1:0] ksa_addr,
  input  logic [AW-1:0] prga_addr,
  input  logic [7:0]    init_wrdata,
  input  logic [7:0]    ksa_wrdata,
  input  logic [7:0]    prga_wrdata,
  input  logic          init_wren,
  input  logic          ksa_wren,
  input  logic          prga_wren,
  output logic [AW-1:0] s_addr,
  output logic [7:0]    s_wrdata,
  output logic          s_wren,
  output logic [1:0]    phase
);
  arc4_seq_state_t state_q, state_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [23:0] key_d;
  logic err_q, err_d, sel_rdy, is_req, tmo, go;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wd_q    <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  always_comb begin
    phase   = state_phase(state_q);
    rdy     = state_q == IDLE;
    err     = err_q;
    sel_rdy = phase == PH_INIT ? init_rdy : phase == PH_KSA ? ksa_rdy : prga_rdy;
    is_req  = state_q == INIT_REQ || state_q == KSA_REQ || state_q == PRGA_REQ;
    tmo     = !rdy && wd_q == TW'(TIMEOUT - 1);
    go      = is_req && sel_rdy && !tmo;
    init_en = go && phase == PH_INIT;
    ksa_en  = go && phase == PH_KSA;
    prga_en = go && phase == PH_PRGA;
    state_d = state_q;
    key_d   = key_q;
    err_d   = err_q;
    if (rdy) begin
      if (en) begin
        state_d = INIT_REQ;
        key_d   = key;
        err_d   = 1'b0;
      end
    end else if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (go)
      state_d = arc4_seq_state_t'(state_q + 3'd1);
    // wd_q == 0 marks the guard cycle, where a stale child rdy must not advance
    else if (!is_req && sel_rdy && wd_q != '0)
      state_d = state_q == PRGA_WAIT ? IDLE : arc4_seq_state_t'(state_q + 3'd1);
    wd_d = (rdy || state_d != state_q) ? '0 : wd_q + TW'(1);
  end
  s_port_mux u_mux (
    .phase       (phase),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );
endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq: drives arc4_seq with stub children and checks it against a per-run phase timeline
module tb_arc4_seq;
  localparam int TO = 3200;
  logic        clk = 1'b0, rst_n = 1'b1, en = 1'b0, clr = 1'b0;
  logic [23:0] key = '0, key_q;
  logic        rdy, err, s_wren;
  logic [2:0]  c_en, c_rdy, c_we = '0, hold = '0;
  logic [7:0]  c_addr [3], c_wd [3];
  logic [7:0]  s_addr, s_wrdata;
  logic [1:0]  phase;
  int          cnt [3], bsy [3];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign c_rdy = {cnt[2] == 0 && !hold[2], cnt[1] == 0 && !hold[1], cnt[0] == 0 && !hold[0]};
  // each stub child drops rdy for bsy[i] cycles after its en edge
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      cnt[i] <= clr ? 0 : c_en[i] ? bsy[i] : cnt[i] > 0 ? cnt[i] - 1 : 0;
  arc4_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .err(err), .key(key), .key_q(key_q),
    .init_en(c_en[0]), .ksa_en(c_en[1]), .prga_en(c_en[2]),
    .init_rdy(c_rdy[0]), .ksa_rdy(c_rdy[1]), .prga_rdy(c_rdy[2]),
    .init_addr(c_addr[0]), .ksa_addr(c_addr[1]), .prga_addr(c_addr[2]),
    .init_wrdata(c_wd[0]), .ksa_wrdata(c_wd[1]), .prga_wrdata(c_wd[2]),
    .init_wren(c_we[0]), .ksa_wren(c_we[1]), .prga_wren(c_we[2]),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .phase(phase)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_reset_outputs();
    check("rst_rdy", rdy, 1);
    check("rst_err", err, 0);
    check("rst_phase", phase, 0);
    check("rst_key_q", key_q, 0);
    check("rst_en", c_en, 0);
    check("rst_s_wren", s_wren, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wrdata", s_wrdata, 0);
  endtask
  // Phase i occupies hold + busy + 2 cycles (REQ incl. held cycles, then busy+1 WAIT cycles);
  // a child that never returns ends its phase TO cycles after its en cycle.
  task automatic run(input logic [23:0] k, input int b0, input int b1, input int b2,
                     input int h1, input int abort_n);
    int st [3], ln [3], h [3], b [3];
    int L, ph;
    bit tmo;
    b = '{b0, b1, b2};
    h = '{0, h1, 0};
    st = '{32'h3fffffff, 32'h3fffffff, 32'h3fffffff};
    ln = '{0, 0, 0};
    L = 0;
    tmo = 0;
    for (int i = 0; i < 3; i++) begin
      st[i] = L;
      if (b[i] >= TO) begin
        ln[i] = h[i] + 1 + TO;
        L += ln[i];
        tmo = 1;
        break;
      end
      ln[i] = h[i] + b[i] + 2;
      L += ln[i];
    end
    bsy = b;
    @(negedge clk);
    check("idle_before_en", rdy, 1);
    clr = 1'b1;
    en = 1'b1;
    key = k;
    @(negedge clk);
    clr = 1'b0;
    for (int n = 0; n <= L; n++) begin
      ph = 0;
      for (int i = 0; i < 3; i++)
        if (n >= st[i] && n < st[i] + ln[i]) ph = i + 1;
      hold = {1'b0, n < st[1] + h1, 1'b0};
      en = n < L && $urandom_range(0, 5) == 0;
      key = 24'($urandom);
      for (int i = 0; i < 3; i++) begin
        c_addr[i] = 8'($urandom);
        c_wd[i] = 8'($urandom);
      end
      c_we = 3'($urandom);
      if (n == abort_n) begin
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          check("no_prga_en_after_rst", c_en[2], 0);
          check("rdy_after_rst", rdy, 1);
        end
        return;
      end
      #1;
      check("phase", phase, ph);
      check("rdy", rdy, n == L);
      check("err", err, n == L && tmo);
      check("key_q", key_q, k);
      for (int i = 0; i < 3; i++)
        check("child_en", c_en[i], ph == i + 1 && n == st[i] + h[i]);
      check("s_addr", s_addr, ph != 0 ? c_addr[ph-1] : 8'h00);
      check("s_wrdata", s_wrdata, ph != 0 ? c_wd[ph-1] : 8'h00);
      check("s_wren", s_wren, ph != 0 ? c_we[ph-1] : 1'b0);
      @(negedge clk);
    end
    en = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      c_addr[i] = '0;
      c_wd[i] = '0;
      bsy[i] = 1;
    end
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rdy", rdy, 1);
    check("idle_en", c_en, 0);
    run(24'h00033C, 1, 3080, 10, 0, -1);
    repeat (8)
      run(24'($urandom), $urandom_range(1, 5), $urandom_range(1, 8),
          $urandom_range(1, 12), $urandom_range(0, 4), -1);
    run(24'($urandom), 2, 4, 3, 5, -1);
    run(24'hA5A5A5, 2, 100000, 3, 0, -1);
    run(24'h5A5A5A, 1, 2, 3, 0, -1);
    run(24'($urandom), 2, 3, 20, 0, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
